// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and default sizing for the parametrised UART
//             receiver (uart_rx_param) and its baud tick generator.
//  Contents : uart_rx_state_t  receiver FSM state encoding
//             c_DBIT, c_OVS, c_SB_TICK, c_DVSR_BIT  default parameters
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int c_DBIT     = 8;   // data bits per frame
    localparam int c_OVS      = 16;  // oversampling ticks per bit
    localparam int c_SB_TICK  = 16;  // ticks spent in the stop bit(s)
    localparam int c_DVSR_BIT = 13;  // width of the baud divisor

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param_if
//  Purpose  : Bundles the serial line, configuration and consumer-side
//             handshake of uart_rx_param.
//  Modports : master - the receiver (drives dout, rx_valid and status)
//             slave  - the pad/config/consumer side (drives rx, dvsr,
//                      parity_odd, rx_ack)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_param_if import uart_pkg::*; #(
    parameter int DBIT     = c_DBIT,
    parameter int DVSR_BIT = c_DVSR_BIT
);
    logic [DVSR_BIT-1:0] dvsr;
    logic                parity_odd;
    logic                rx;
    logic                rx_ack;
    logic [DBIT-1:0]     dout;
    logic                rx_valid;
    logic                rx_done_tick;
    logic                frame_err;
    logic                parity_err;
    logic                break_det;
    logic                overrun_err;

    modport master (
        input  dvsr, parity_odd, rx, rx_ack,
        output dout, rx_valid, rx_done_tick, frame_err, parity_err,
               break_det, overrun_err
    );

    modport slave (
        output dvsr, parity_odd, rx, rx_ack,
        input  dout, rx_valid, rx_done_tick, frame_err, parity_err,
               break_det, overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Oversampling tick generator. Counts 0..dvsr_q and pulses tick
//             when the count equals dvsr_q (period dvsr_q+1 clocks).
//             clr restarts the count and latches dvsr, so each frame runs
//             with one divisor and a phase aligned to its start edge.
//  Ports    : clk, reset (async, active high), dvsr (divisor), clr,
//             tick (1-clock pulse)
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DVSR_BIT = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                clr,
    output logic                tick
);
    logic [DVSR_BIT-1:0] r_cnt;
    logic [DVSR_BIT-1:0] r_dvsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dvsr_q <= '0;
        end else if (clr) begin
            r_cnt    <= '0;
            r_dvsr_q <= dvsr;
        end else if (r_cnt == r_dvsr_q) begin
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + DVSR_BIT'(1);
        end
    end

    assign tick = (r_cnt == r_dvsr_q);
endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised oversampling UART receiver with a held output
//             word, rx_ack handshake and framing/break/overrun/parity status.
//  Ports    : clk, reset (async, active high)
//             bus (uart_rx_param_if.master):
//               dvsr, parity_odd, rx, rx_ack       inputs
//               dout, rx_valid, rx_done_tick,
//               frame_err, parity_err, break_det,
//               overrun_err                        outputs
//  Options  : UART_PARITY_EN - adds a parity bit after the data bits and
//             drives parity_err; otherwise parity_err is 0.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_param import uart_pkg::*; #(
    parameter int DBIT     = c_DBIT,
    parameter int OVS      = c_OVS,
    parameter int SB_TICK  = c_SB_TICK,
    parameter int DVSR_BIT = c_DVSR_BIT
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_param_if.master bus
);
    // Tick counter must hold up to 2*OVS-1 (two stop bits).
    localparam int c_S_W = $clog2(2 * OVS);
    localparam int c_N_W = $clog2(DBIT);
    localparam logic [c_S_W-1:0] c_S_HALF = c_S_W'(OVS / 2 - 1);
    localparam logic [c_S_W-1:0] c_S_BIT  = c_S_W'(OVS - 1);
    localparam logic [c_S_W-1:0] c_S_STOP = c_S_W'(SB_TICK - 1);
    localparam logic [c_N_W-1:0] c_N_LAST = c_N_W'(DBIT - 1);

    logic [1:0]       r_sync;
    logic             w_rx_s;
    uart_rx_state_t   r_state, w_state_next;
    logic [c_S_W-1:0] r_s, w_s_next;
    logic [c_N_W-1:0] r_n, w_n_next;
    logic [DBIT-1:0]  r_b, w_b_next;
    logic             w_tick, w_clr, w_done, w_par_err;

    logic [DBIT-1:0]  r_dout;
    logic             r_valid, r_done_tick, r_frame_err, r_parity_err;
    logic             r_break_det, r_overrun_err;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], bus.rx};
    end
    assign w_rx_s = r_sync[1];

    uart_baud_gen #(.DVSR_BIT(DVSR_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .dvsr  (bus.dvsr),
        .clr   (w_clr),
        .tick  (w_tick)
    );

`ifdef UART_PARITY_EN
    logic r_pbit, w_pbit_next;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pbit <= 1'b0;
        else       r_pbit <= w_pbit_next;
    end
    assign w_par_err = (^{r_b, r_pbit}) ^ bus.parity_odd;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = bus.parity_odd;
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_clr        = 1'b0;
        w_done       = 1'b0;
`ifdef UART_PARITY_EN
        w_pbit_next  = r_pbit;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_s_next     = '0;
                    w_clr        = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == c_S_HALF) begin
                        // Start bit must still be low at mid-bit, else glitch.
                        w_state_next = w_rx_s ? IDLE : DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == c_S_BIT) begin
                        w_s_next = '0;
                        w_b_next = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n == c_N_LAST) begin
`ifdef UART_PARITY_EN
                            w_state_next = PARITY;
`else
                            w_state_next = STOP;
`endif
                        end else begin
                            w_n_next = r_n + c_N_W'(1);
                        end
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (r_s == c_S_BIT) begin
                        w_pbit_next  = w_rx_s;
                        w_state_next = STOP;
                        w_s_next     = '0;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_s == c_S_STOP) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                        w_s_next     = '0;
                    end else begin
                        w_s_next = r_s + c_S_W'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output holding register. A completing frame is only accepted when the
    // previous word is gone (or being acked this cycle); otherwise it is
    // dropped and recorded as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout        <= '0;
            r_valid       <= 1'b0;
            r_done_tick   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_break_det   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_done_tick <= w_done;
            if (w_done) begin
                if (!r_valid || bus.rx_ack) begin
                    r_dout       <= r_b;
                    r_valid      <= 1'b1;
                    r_frame_err  <= ~w_rx_s;
                    r_break_det  <= (r_b == '0) & ~w_rx_s;
                    r_parity_err <= w_par_err;
                end else begin
                    r_overrun_err <= 1'b1;
                end
            end else if (bus.rx_ack && r_valid) begin
                r_valid       <= 1'b0;
                r_overrun_err <= 1'b0;
            end
        end
    end

    assign bus.dout         = r_dout;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_done_tick = r_done_tick;
    assign bus.frame_err    = r_frame_err;
    assign bus.parity_err   = r_parity_err;
    assign bus.break_det    = r_break_det;
    assign bus.overrun_err  = r_overrun_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Directed self-checking bench for uart_rx_param
//             (DBIT=8, OVS=16, SB_TICK=16). Build with UART_PARITY_EN
//             defined to include the parity frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;
    import uart_pkg::*;

`ifdef UART_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    uart_rx_param_if #(.DBIT(c_DBIT), .DVSR_BIT(c_DVSR_BIT)) bus ();

    uart_rx_param #(
        .DBIT(c_DBIT), .OVS(c_OVS), .SB_TICK(c_SB_TICK), .DVSR_BIT(c_DVSR_BIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;
    int base;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.rx_done_tick === 1'b1) begin
            n_done = n_done + 1;
            last_done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_clks();
        return (int'(bus.dvsr) + 1) * c_OVS;
    endfunction

    // Start edge to visible rx_done_tick, in clocks: sync + IDLE->START
    // register + tick budget of the frame.
    function automatic int exp_latency();
        return 3 + (c_OVS / 2 + c_DBIT * c_OVS + c_PAR * c_OVS + c_SB_TICK)
                   * (int'(bus.dvsr) + 1);
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (bit_clks()) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_v,
                              input logic pbit, input int gap_bits);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < c_DBIT; i++) send_bit(data[i]);
        if (c_PAR == 1) send_bit(pbit);
        send_bit(stop_v);
        bus.rx = 1'b1;
        for (int i = 0; i < gap_bits; i++) send_bit(1'b1);
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_latency(input string tag);
        int lat;
        int e;
        lat = last_done_cyc - start_cyc;
        e   = exp_latency();
        check_eq(tag, 32'((lat >= e - 3) && (lat <= e + 3)), 32'd1);
    endtask

    initial begin
        bus.rx         = 1'b1;
        bus.rx_ack     = 1'b0;
        bus.dvsr       = 13'd9;
        bus.parity_odd = 1'b0;
        reset          = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        check_eq("rst_dout",    32'(bus.dout),         32'h0);
        check_eq("rst_valid",   32'(bus.rx_valid),     32'h0);
        check_eq("rst_done",    32'(bus.rx_done_tick), 32'h0);
        check_eq("rst_frame",   32'(bus.frame_err),    32'h0);
        check_eq("rst_parity",  32'(bus.parity_err),   32'h0);
        check_eq("rst_break",   32'(bus.break_det),    32'h0);
        check_eq("rst_overrun", 32'(bus.overrun_err),  32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: clean 0xA5 frame
        base = n_done;
        send_frame(8'hA5, 1'b1, even_par(8'hA5), 2);
        check_eq("t1_pulses",  32'(n_done - base),    32'd1);
        check_eq("t1_dout",    32'(bus.dout),         32'hA5);
        check_eq("t1_valid",   32'(bus.rx_valid),     32'h1);
        check_eq("t1_frame",   32'(bus.frame_err),    32'h0);
        check_eq("t1_parity",  32'(bus.parity_err),   32'h0);
        check_eq("t1_break",   32'(bus.break_det),    32'h0);
        check_eq("t1_overrun", 32'(bus.overrun_err),  32'h0);
        check_latency("t1_latency");
        ack_pulse();
        check_eq("t1_ack_valid", 32'(bus.rx_valid), 32'h0);

        // 2: back-to-back frames without ack -> overrun
        base = n_done;
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 0);
        send_frame(8'hC3, 1'b1, even_par(8'hC3), 2);
        check_eq("t2_pulses",  32'(n_done - base),   32'd2);
        check_eq("t2_dout",    32'(bus.dout),        32'h3C);
        check_eq("t2_valid",   32'(bus.rx_valid),    32'h1);
        check_eq("t2_overrun", 32'(bus.overrun_err), 32'h1);
        ack_pulse();
        check_eq("t2_ack_valid",   32'(bus.rx_valid),    32'h0);
        check_eq("t2_ack_overrun", 32'(bus.overrun_err), 32'h0);

        // 3: framing error, then a break
        send_frame(8'h55, 1'b0, even_par(8'h55), 2);
        check_eq("t3_dout",  32'(bus.dout),      32'h55);
        check_eq("t3_frame", 32'(bus.frame_err), 32'h1);
        check_eq("t3_break", 32'(bus.break_det), 32'h0);
        ack_pulse();
        bus.rx = 1'b0;
        repeat (12 * bit_clks()) @(negedge clk);
        check_eq("t3b_dout",  32'(bus.dout),      32'h00);
        check_eq("t3b_valid", 32'(bus.rx_valid),  32'h1);
        check_eq("t3b_frame", 32'(bus.frame_err), 32'h1);
        check_eq("t3b_break", 32'(bus.break_det), 32'h1);
        bus.rx = 1'b1;
        repeat (15 * bit_clks()) @(negedge clk);
        ack_pulse();
        check_eq("t3b_ack_valid",   32'(bus.rx_valid),    32'h0);
        check_eq("t3b_ack_overrun", 32'(bus.overrun_err), 32'h0);

        // 4: short glitch rejected, following frame still received
        base = n_done;
        bus.rx = 1'b0;
        repeat (40) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * bit_clks()) @(negedge clk);
        check_eq("t4_glitch_pulses", 32'(n_done - base), 32'd0);
        check_eq("t4_glitch_valid",  32'(bus.rx_valid),  32'h0);
        base = n_done;
        send_frame(8'h81, 1'b1, even_par(8'h81), 2);
        check_eq("t4_pulses", 32'(n_done - base),   32'd1);
        check_eq("t4_dout",   32'(bus.dout),        32'h81);
        check_eq("t4_valid",  32'(bus.rx_valid),    32'h1);
        check_eq("t4_frame",  32'(bus.frame_err),   32'h0);

        // 6: reset mid-frame, then a new divisor
        base = n_done;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_dout",    32'(bus.dout),         32'h0);
        check_eq("t6_rst_valid",   32'(bus.rx_valid),     32'h0);
        check_eq("t6_rst_done",    32'(bus.rx_done_tick), 32'h0);
        check_eq("t6_rst_overrun", 32'(bus.overrun_err),  32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10 * bit_clks()) @(negedge clk);
        check_eq("t6_no_pulse", 32'(n_done - base), 32'd0);
        bus.dvsr = 13'd4;
        base = n_done;
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 2);
        check_eq("t6_pulses", 32'(n_done - base),  32'd1);
        check_eq("t6_dout",   32'(bus.dout),       32'h3C);
        check_eq("t6_valid",  32'(bus.rx_valid),   32'h1);
        check_latency("t6_latency");
        ack_pulse();

`ifdef UART_PARITY_EN
        // 5: parity checking
        bus.parity_odd = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 2);
        check_eq("t5_even_ok",  32'(bus.parity_err), 32'h0);
        ack_pulse();
        send_frame(8'hA5, 1'b1, 1'b1, 2);
        check_eq("t5_even_bad", 32'(bus.parity_err), 32'h1);
        ack_pulse();
        bus.parity_odd = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1, 2);
        check_eq("t5_odd_ok",   32'(bus.parity_err), 32'h0);
        ack_pulse();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
